// File: rtl/ff_pkg.sv
// Shared types and excitation constants for the flip-flop excitation driver.
package ff_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      DRIVE = 2'b01,
      CHECK = 2'b10
   } ff_state_t;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_RST  = 2'b01;
   localparam logic [1:0] JK_TGL  = 2'b11;

   localparam logic [1:0] SR_HOLD = 2'b00;
   localparam logic [1:0] SR_SET  = 2'b10;
   localparam logic [1:0] SR_RST  = 2'b01;

endpackage

// File: rtl/ff_excite_lut.sv
// Excitation table: current Q and desired Q to JK and SR pairs.
// Build option JK_TOGGLE_EN drives JK=11 on every state change.
module ff_excite_lut
   import ff_pkg::*;
(
   input  logic       cur,
   input  logic       exp,
   output logic [1:0] JK,
   output logic [1:0] SR
);

   // Table lookup; SR never produces the forbidden 11 code.
   always_comb begin
      JK = JK_HOLD;
      SR = SR_HOLD;
      case ({cur, exp})
         2'b00: begin
            JK = JK_HOLD;
            SR = SR_HOLD;
         end
         2'b01: begin
`ifdef JK_TOGGLE_EN
            JK = JK_TGL;
`else
            JK = JK_SET;
`endif
            SR = SR_SET;
         end
         2'b10: begin
`ifdef JK_TOGGLE_EN
            JK = JK_TGL;
`else
            JK = JK_RST;
`endif
            SR = SR_RST;
         end
         2'b11: begin
            JK = JK_HOLD;
            SR = SR_HOLD;
         end
         default: begin
            JK = JK_HOLD;
            SR = SR_HOLD;
         end
      endcase
   end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a target flip-flop toward each requested Q, checks the readback,
// and counts mismatches. Optional JK_TOGGLE_EN selects toggle excitation.
module jk_excitation_driver
   import ff_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tgt_valid,
   input  logic             tgt_q,
   output logic             tgt_ready,
   output logic [1:0]       JK,
   output logic [1:0]       SR,
   input  logic             q_fb,
   output logic             err,
   output logic [CNT_W-1:0] mis_cnt,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   ff_state_t        r_state;
   logic [1:0]       r_jk;
   logic [1:0]       r_sr;
   logic             r_tgt_ready;
   logic             r_err;
   logic [CNT_W-1:0] r_mis_cnt;
   logic             r_busy;
   logic             r_exp_q;

   logic [1:0]       w_jk;
   logic [1:0]       w_sr;

   // Excitation is looked up from the live feedback so it can be registered at accept.
   ff_excite_lut u_lut (
      .cur (q_fb),
      .exp (tgt_q),
      .JK  (w_jk),
      .SR  (w_sr)
   );

   // Step sequencer: accept, drive for one cycle, then check readback.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_jk        <= JK_HOLD;
         r_sr        <= SR_HOLD;
         r_tgt_ready <= 1'b1;
         r_err       <= 1'b0;
         r_mis_cnt   <= {CNT_W{1'b0}};
         r_busy      <= 1'b0;
         r_exp_q     <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (tgt_valid && r_tgt_ready) begin
                  r_exp_q     <= tgt_q;
                  r_jk        <= w_jk;
                  r_sr        <= w_sr;
                  r_tgt_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= DRIVE;
               end else begin
                  r_state <= IDLE;
               end
            end
            DRIVE: begin
               r_jk    <= JK_HOLD;
               r_sr    <= SR_HOLD;
               r_state <= CHECK;
            end
            CHECK: begin
               // The target registered the excitation on the previous edge.
               if (q_fb != r_exp_q) begin
                  r_err <= 1'b1;
                  if (r_mis_cnt != CNT_MAX) begin
                     r_mis_cnt <= r_mis_cnt + CNT_ONE;
                  end else begin
                     r_mis_cnt <= r_mis_cnt;
                  end
               end else begin
                  r_err <= 1'b0;
               end
               r_tgt_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
            default: begin
               r_state     <= IDLE;
               r_jk        <= JK_HOLD;
               r_sr        <= SR_HOLD;
               r_tgt_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign tgt_ready = r_tgt_ready;
   assign JK        = r_jk;
   assign SR        = r_sr;
   assign err       = r_err;
   assign mis_cnt   = r_mis_cnt;
   assign busy      = r_busy;

endmodule
